// File: rtl/matrix_row_driver_pkg.sv
// Shared definitions for the matrix row driver: column ring encoding,
// storage geometry and row drive polarity helpers.
package matrix_row_driver_pkg;

  localparam int unsigned ROWS_DEFAULT = 7;
  localparam int unsigned STORED_COLS  = 3;

  typedef logic [STORED_COLS-1:0] col_t;

  // Ring reset state and the last column before the frame wraps.
  localparam col_t COL_RESET = 3'b100;
  localparam col_t COL_LAST  = 3'b001;

  function automatic logic col_is_onehot(col_t c);
    return $onehot(c);
  endfunction

  function automatic logic row_off_level(bit active_low);
    return active_low;
  endfunction

  function automatic logic row_on_level(bit active_low);
    return !active_low;
  endfunction

endpackage

// File: rtl/matrix_row_driver_if.sv
// Column select, image load handshake and row drive bundle between the
// column ring / image source (master) and the row driver (slave).
interface matrix_row_driver_if #(
  parameter int unsigned ROWS = 7
);
  logic [2:0]        col;
  logic [3*ROWS-1:0] img_data;
  logic              img_valid;
  logic              img_ready;
  logic [ROWS-1:0]   row;
  logic              frame_swap;
  logic              col_err;

  modport master (
    output col, img_data, img_valid,
    input  img_ready, row, frame_swap, col_err
  );

  modport slave (
    input  col, img_data, img_valid,
    output img_ready, row, frame_swap, col_err
  );
endinterface

// File: rtl/matrix_row_driver_blank_timer.sv
// Anti-ghosting blank timer: reloads on every column change and counts down;
// busy_next reports whether rows must be held off at the coming edge.
module matrix_row_driver_blank_timer #(
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic busy_next
);

  localparam int unsigned CW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // NOTE: cnt_next gets a value on every path so no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (load)
      cnt_next = CW'(BLANK_CYCLES);
    else if (cnt != '0)
      cnt_next = cnt - CW'(1);
  end

  assign busy_next = (cnt_next != '0);

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_next;
  end

endmodule

// File: rtl/matrix_row_driver.sv
// Row driver for a 3-column mirrored LED matrix: double-buffered image,
// frame-boundary swap, post-change blanking and illegal column detection.
module matrix_row_driver
  import matrix_row_driver_pkg::*;
#(
  parameter int unsigned ROWS           = ROWS_DEFAULT,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter bit          ROW_ACTIVE_LOW = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  matrix_row_driver_if.slave   bus
);

  localparam logic [ROWS-1:0] ROW_OFF = {ROWS{row_off_level(ROW_ACTIVE_LOW)}};
  localparam logic             LIT     = row_on_level(ROW_ACTIVE_LOW);
  localparam logic             DARK    = row_off_level(ROW_ACTIVE_LOW);

  col_t                      col_q;
  logic [STORED_COLS*ROWS-1:0] active;
  logic [STORED_COLS*ROWS-1:0] shadow;
  logic                      pending;
  logic [ROWS-1:0]           row_q;
  logic                      frame_swap_q;
  logic                      col_err_q;

  logic            col_ok;
  logic            col_change;
  logic            boundary;
  logic            load;
  logic            blank_busy;
  logic [ROWS-1:0] row_pat;
  logic [ROWS-1:0] row_next;

  assign col_ok     = col_is_onehot(bus.col);
  assign col_change = (bus.col != col_q);
  // An illegal col can never equal COL_RESET, so no boundary is seen then.
  assign boundary   = (col_q == COL_LAST) && (bus.col == COL_RESET);
  assign load       = bus.img_valid && !pending;

  matrix_row_driver_blank_timer #(
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_blank_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (col_change),
    .busy_next (blank_busy)
  );

  always_comb begin
    row_pat = '0;
    for (int i = 0; i < STORED_COLS; i++) begin
      if (bus.col == col_t'(1 << i))
        row_pat = active[i*ROWS +: ROWS];
    end
    row_next = ROW_OFF;
    if (!blank_busy && col_ok) begin
      for (int r = 0; r < ROWS; r++)
        row_next[r] = row_pat[r] ? LIT : DARK;
    end
  end

  // NOTE: image buffers are reset too, so a reset discards a pending load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q        <= COL_RESET;
      active       <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      row_q        <= ROW_OFF;
      frame_swap_q <= 1'b0;
      col_err_q    <= 1'b0;
    end else begin
      col_q        <= bus.col;
      row_q        <= row_next;
      frame_swap_q <= boundary && pending;
      col_err_q    <= col_err_q || !col_ok;
      if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= bus.img_data;
        pending <= 1'b1;
      end
    end
  end

  assign bus.img_ready  = !pending;
  assign bus.row        = row_q;
  assign bus.frame_swap = frame_swap_q;
  assign bus.col_err    = col_err_q;

endmodule

// File: tb/tb_matrix_row_driver.sv
// Directed-plus-random bench for matrix_row_driver (ROWS=7, active-low rows),
// with a second BLANK_CYCLES=0 instance sharing the same stimulus.
module tb_matrix_row_driver;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  matrix_row_driver_if #(.ROWS(7)) bus  ();
  matrix_row_driver_if #(.ROWS(7)) bus0 ();

  assign bus0.col       = bus.col;
  assign bus0.img_data  = bus.img_data;
  assign bus0.img_valid = bus.img_valid;

  matrix_row_driver #(.ROWS(7), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  matrix_row_driver #(.ROWS(7), .BLANK_CYCLES(0), .ROW_ACTIVE_LOW(1'b1)) dut_nb (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: displayed image, staged image, load-pending flag,
  // previous column and the last three sampled columns.
  logic [20:0] m_act;
  logic [20:0] m_shd;
  bit          m_pend;
  bit          m_err;
  logic [2:0]  m_prev;
  logic [2:0]  hist[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act  = '0;
    m_shd  = '0;
    m_pend = 1'b0;
    m_err  = 1'b0;
    m_prev = 3'b100;
    hist.delete();
    repeat (3) hist.push_back(3'b100);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_row"},   32'(bus.row),        32'h7F);
    check({tag, "_row0"},  32'(bus0.row),       32'h7F);
    check({tag, "_ready"}, 32'(bus.img_ready),  32'd1);
    check({tag, "_swap"},  32'(bus.frame_swap), 32'd0);
    check({tag, "_err"},   32'(bus.col_err),    32'd0);
  endtask

  // One clock: predict from the current inputs, let the edge happen, compare.
  task automatic tick();
    logic [2:0] c;
    logic [6:0] pat;
    logic [6:0] exp_row;
    logic [6:0] exp_row0;
    bit         oh;
    bit         steady;
    bit         exp_swap;
    c  = bus.col;
    oh = $onehot(c);
    hist.push_back(c);
    if (hist.size() > 3) void'(hist.pop_front());
    steady = 1'b1;
    foreach (hist[i]) if (hist[i] != c) steady = 1'b0;
    pat = '0;
    for (int i = 0; i < 3; i++) if (c == 3'(1 << i)) pat = m_act[i*7 +: 7];
    exp_row  = (oh && steady) ? ~pat : 7'h7F;
    exp_row0 = oh ? ~pat : 7'h7F;
    exp_swap = (m_prev == 3'b001) && (c == 3'b100) && m_pend;
    if (exp_swap) begin
      m_act  = m_shd;
      m_pend = 1'b0;
    end else if (bus.img_valid && !m_pend) begin
      m_shd  = bus.img_data;
      m_pend = 1'b1;
    end
    m_err  = m_err || !oh;
    m_prev = c;
    @(posedge clock);
    #1;
    check("row",   32'(bus.row),        32'(exp_row));
    check("row0",  32'(bus0.row),       32'(exp_row0));
    check("swap",  32'(bus.frame_swap), 32'(exp_swap));
    check("ready", 32'(bus.img_ready),  32'(!m_pend));
    check("err",   32'(bus.col_err),    32'(m_err));
  endtask

  task automatic run_col(logic [2:0] c, int n);
    bus.col = c;
    repeat (n) tick();
  endtask

  task automatic frame();
    run_col(3'b100, 4);
    run_col(3'b010, 4);
    run_col(3'b001, 4);
  endtask

  task automatic pulse_load(logic [20:0] d);
    bus.img_valid = 1'b1;
    bus.img_data  = d;
    tick();
    bus.img_valid = 1'b0;
    bus.img_data  = 21'($urandom);
  endtask

  task automatic random_col(logic [2:0] c);
    bus.col = c;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 3) == 0) pulse_load(21'($urandom));
      else tick();
    end
  endtask

  initial begin
    bus.col       = 3'b100;
    bus.img_valid = 1'b0;
    bus.img_data  = '0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Blank ring, no image loaded.
    repeat (3) frame();

    // Mid-frame load, swap at the wrap, then show the image.
    run_col(3'b100, 2);
    bus.col = 3'b010;
    tick();
    pulse_load({7'h41, 7'h22, 7'h1C});
    tick();
    tick();
    run_col(3'b001, 4);
    repeat (2) frame();

    // Load on the same edge as the wrap; a second load while pending is dropped.
    bus.col = 3'b100;
    pulse_load(21'($urandom));
    run_col(3'b100, 3);
    bus.col = 3'b010;
    tick();
    pulse_load(21'($urandom));
    tick();
    tick();
    run_col(3'b001, 4);
    repeat (2) frame();

    // Randomised load timing and image contents.
    repeat (6) begin
      random_col(3'b100);
      random_col(3'b010);
      random_col(3'b001);
    end

    // Illegal multi-hot column for one clock.
    run_col(3'b100, 2);
    run_col(3'b110, 1);
    run_col(3'b010, 4);
    run_col(3'b001, 4);
    frame();

    // Reset mid-column while a load is pending.
    run_col(3'b100, 2);
    bus.col = 3'b010;
    tick();
    pulse_load(21'($urandom) | 21'h1);
    tick();
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    #2;
    reset = 1'b0;
    run_col(3'b010, 3);
    run_col(3'b001, 4);
    repeat (2) frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
